// File: rtl/tweet_store_pkg.sv
// Shared state encodings and constants for the serial message store.
package tweet_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_STOP   = 3'd3,
        RX_COMMIT = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_FETCH = 3'd1,
        TX_START = 3'd2,
        TX_DATA  = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_t;

    localparam logic [7:0] BS_DEFAULT = 8'h08;

endpackage

// File: rtl/tweet_store_msg_ram.sv
// Simple dual-port message buffer: one write port, one registered read port, no reset.
module msg_ram
    import tweet_pkg::*;
#(
    parameter int DEPTH     = 160,
    parameter int AW        = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 sysclk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [DATA_BITS-1:0] rdata_r;

    // Write port and synchronous read port share the single clock.
    always_ff @(posedge sysclk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/tweet_store.sv
// Serial message store: receives UART frames into a buffer with backspace editing,
// echoes the line while not full, and replays the whole buffer on a play pulse.
module tweet_store
    import tweet_pkg::*;
#(
    parameter int                   CLK_DIV   = 5208,
    parameter int                   DEPTH     = 160,
    parameter int                   AW        = 8,
    parameter int                   DATA_BITS = 8,
    parameter logic [DATA_BITS-1:0] BS_CODE   = DATA_BITS'(BS_DEFAULT)
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rx_in,
    input  logic        play,
    input  logic        clear,
    output logic        tx_out,
    output logic        busy,
    output logic [AW:0] count,
    output logic        full,
    output logic        overflow,
    output logic        framing_err
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV / 2 - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(0);

    logic                 rx_meta_r, rx_sync_r, rx_prev_r;
    logic                 rx_fall_s;
    rx_state_t            rx_state_r, rx_state_s;
    logic [DW-1:0]        rx_div_r;
    logic [BW-1:0]        rx_bit_r;
    logic [DATA_BITS-1:0] rx_shift_r;
    logic                 rx_stop_r;

    tx_state_t            tx_state_r, tx_state_s;
    logic [DW-1:0]        tx_div_r;
    logic [BW-1:0]        tx_bit_r;
    logic [DATA_BITS-1:0] tx_shift_r;
    logic [AW:0]          tx_idx_r;
    logic                 tx_out_r, tx_bit_s;
    logic                 busy_r;

    logic [AW:0]          count_r, count_s;
    logic                 full_r, ovf_r, ovf_s, ferr_r, ferr_s;
    logic                 we_s, play_ok_s;
    logic [DATA_BITS-1:0] rd_data_s;

    assign rx_fall_s = rx_prev_r & ~rx_sync_r;
    assign play_ok_s = play & ~clear & (rx_state_r == RX_IDLE) & ~busy_r & (count_r != CNT_ZERO);

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_in;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX next state; receiver is parked while playback owns the buffer.
    always_comb begin
        rx_state_s = rx_state_r;
        if (clear) begin
            rx_state_s = RX_IDLE;
        end else begin
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_fall_s && !busy_r && !play_ok_s) rx_state_s = RX_START;
                    else                                    rx_state_s = RX_IDLE;
                end
                RX_START: begin
                    if (rx_div_r == HALF_LAST) rx_state_s = rx_sync_r ? RX_IDLE : RX_DATA;
                    else                       rx_state_s = RX_START;
                end
                RX_DATA: begin
                    if (rx_div_r == DIV_LAST && rx_bit_r == BIT_LAST) rx_state_s = RX_STOP;
                    else                                              rx_state_s = RX_DATA;
                end
                RX_STOP: begin
                    if (rx_div_r == DIV_LAST) rx_state_s = RX_COMMIT;
                    else                      rx_state_s = RX_STOP;
                end
                RX_COMMIT: rx_state_s = RX_IDLE;
                default:   rx_state_s = RX_IDLE;
            endcase
        end
    end

    // RX state, bit timer and mid-bit sampling shift register.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_state_r <= RX_IDLE;
            rx_div_r   <= {DW{1'b0}};
            rx_bit_r   <= {BW{1'b0}};
            rx_shift_r <= {DATA_BITS{1'b0}};
            rx_stop_r  <= 1'b0;
        end else begin
            rx_state_r <= rx_state_s;
            if (rx_state_s != rx_state_r || rx_state_r == RX_IDLE || rx_div_r == DIV_LAST) begin
                rx_div_r <= {DW{1'b0}};
            end else begin
                rx_div_r <= rx_div_r + DIV_ONE;
            end
            if (rx_state_r != RX_DATA) begin
                rx_bit_r <= {BW{1'b0}};
            end else if (rx_div_r == DIV_LAST) begin
                rx_bit_r   <= rx_bit_r + BIT_ONE;
                rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
            end else begin
                rx_bit_r <= rx_bit_r;
            end
            if (rx_state_r == RX_STOP && rx_div_r == DIV_LAST) begin
                rx_stop_r <= rx_sync_r;
            end
        end
    end

    // Commit rules: framing check, backspace, store, or overflow; clear overrides a commit.
    always_comb begin
        we_s    = 1'b0;
        count_s = count_r;
        ovf_s   = ovf_r;
        ferr_s  = ferr_r;
        if (clear) begin
            count_s = CNT_ZERO;
            ovf_s   = 1'b0;
            ferr_s  = 1'b0;
        end else if (rx_state_r == RX_COMMIT) begin
            if (!rx_stop_r) begin
                ferr_s = 1'b1;
            end else if (rx_shift_r == BS_CODE) begin
                if (count_r != CNT_ZERO) count_s = count_r - CNT_ONE;
                else                     count_s = count_r;
            end else if (count_r < DEPTH_C) begin
                we_s    = 1'b1;
                count_s = count_r + CNT_ONE;
            end else begin
                ovf_s = 1'b1;
            end
        end else begin
            count_s = count_r;
        end
    end

    // Buffer fill level and sticky status flags.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            count_r <= CNT_ZERO;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            count_r <= count_s;
            full_r  <= (count_s == DEPTH_C);
            ovf_r   <= ovf_s;
            ferr_r  <= ferr_s;
        end
    end

    msg_ram #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .DATA_BITS (DATA_BITS)
    ) u_ram (
        .sysclk (sysclk),
        .we     (we_s),
        .waddr  (count_r[AW-1:0]),
        .wdata  (rx_shift_r),
        .raddr  (tx_idx_r[AW-1:0]),
        .rdata  (rd_data_s)
    );

    // TX next state; the next byte is read during the stop bit so frames abut.
    always_comb begin
        tx_state_s = tx_state_r;
        if (clear) begin
            tx_state_s = TX_IDLE;
        end else begin
            case (tx_state_r)
                TX_IDLE:  tx_state_s = play_ok_s ? TX_FETCH : TX_IDLE;
                TX_FETCH: tx_state_s = TX_START;
                TX_START: begin
                    if (tx_div_r == DIV_LAST) tx_state_s = TX_DATA;
                    else                      tx_state_s = TX_START;
                end
                TX_DATA: begin
                    if (tx_div_r == DIV_LAST && tx_bit_r == BIT_LAST) tx_state_s = TX_STOP;
                    else                                              tx_state_s = TX_DATA;
                end
                TX_STOP: begin
                    if (tx_div_r == DIV_LAST) tx_state_s = (tx_idx_r == count_r) ? TX_IDLE : TX_START;
                    else                      tx_state_s = TX_STOP;
                end
                default: tx_state_s = TX_IDLE;
            endcase
        end
    end

    // Line level for the following cycle, derived from the current TX state.
    always_comb begin
        tx_bit_s = 1'b1;
        case (tx_state_r)
            TX_IDLE:  tx_bit_s = full_r ? 1'b1 : rx_sync_r;
            TX_FETCH: tx_bit_s = 1'b1;
            TX_START: tx_bit_s = 1'b0;
            TX_DATA:  tx_bit_s = tx_shift_r[0];
            TX_STOP:  tx_bit_s = 1'b1;
            default:  tx_bit_s = 1'b1;
        endcase
    end

    // TX state, bit timer, byte index and registered line/busy outputs.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_state_r <= TX_IDLE;
            tx_div_r   <= {DW{1'b0}};
            tx_bit_r   <= {BW{1'b0}};
            tx_shift_r <= {DATA_BITS{1'b0}};
            tx_idx_r   <= CNT_ZERO;
            tx_out_r   <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            if (tx_state_s != tx_state_r || tx_state_r == TX_IDLE || tx_div_r == DIV_LAST) begin
                tx_div_r <= {DW{1'b0}};
            end else begin
                tx_div_r <= tx_div_r + DIV_ONE;
            end
            if (tx_state_r != TX_DATA) begin
                tx_bit_r <= {BW{1'b0}};
            end else if (tx_div_r == DIV_LAST) begin
                tx_bit_r <= tx_bit_r + BIT_ONE;
            end else begin
                tx_bit_r <= tx_bit_r;
            end
            if (tx_state_r == TX_START && tx_div_r == DIV_LAST) begin
                tx_shift_r <= rd_data_s;
            end else if (tx_state_r == TX_DATA && tx_div_r == DIV_LAST) begin
                tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
            end
            if (play_ok_s) begin
                tx_idx_r <= CNT_ZERO;
            end else if (tx_state_r == TX_DATA && tx_state_s == TX_STOP) begin
                tx_idx_r <= tx_idx_r + CNT_ONE;
            end
            tx_out_r <= clear ? 1'b1 : tx_bit_s;
            busy_r   <= ~clear & ((tx_state_r != TX_IDLE) | play_ok_s);
        end
    end

    assign tx_out      = tx_out_r;
    assign busy        = busy_r;
    assign count       = count_r;
    assign full        = full_r;
    assign overflow    = ovf_r;
    assign framing_err = ferr_r;

endmodule

// File: tb/tb_tweet_store.sv
// Directed self-checking bench for tweet_store with CLK_DIV=16, DEPTH=4.
module tb_tweet_store;

    localparam int CD = 16;
    localparam int FR = 10 * CD;

    logic       sysclk, reset, rx_in, play, clear;
    logic       tx_out, busy, full, overflow, framing_err;
    logic [3:0] count;
    int         checks = 0;
    int         errors = 0;

    tweet_store #(.CLK_DIV(CD), .DEPTH(4), .AW(3), .DATA_BITS(8), .BS_CODE(8'h08)) dut (
        .sysclk(sysclk), .reset(reset), .rx_in(rx_in), .play(play), .clear(clear),
        .tx_out(tx_out), .busy(busy), .count(count), .full(full),
        .overflow(overflow), .framing_err(framing_err)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Sends one frame; optionally pulses play at a given cycle inside the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int play_cyc);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int c = 0; c < FR; c++) begin
            rx_in = f[c/CD];
            play  = (c == play_cyc);
            tick(1);
        end
        play  = 1'b0;
        rx_in = 1'b1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic glitch(input logic exp_tx, input string tag);
        rx_in = 1'b0;
        tick(4);
        check(tag, tx_out, exp_tx);
        rx_in = 1'b1;
        tick(20);
    endtask

    // Pulses play, records the line every cycle and decodes n frames.
    task automatic play_check(input int n, input logic [31:0] exp, input string tag);
        logic rec_tx   [0:699];
        logic rec_busy [0:699];
        int   total, busy_cnt;
        total    = 2 + n * FR;
        busy_cnt = 0;
        play = 1'b1;
        tick(1);
        play = 1'b0;
        for (int k = 0; k <= total + 8; k++) begin
            @(negedge sysclk);
            rec_tx[k]   = tx_out;
            rec_busy[k] = busy;
            if (busy) busy_cnt++;
        end
        check({tag, " busy_rise"}, rec_busy[0], 1'b1);
        check({tag, " start_lat"}, {rec_tx[1], rec_tx[2]}, 2'b10);
        check({tag, " busy_len"}, busy_cnt, total);
        check({tag, " busy_fall"}, {rec_busy[total-1], rec_busy[total]}, 2'b10);
        for (int i = 0; i < n; i++) begin
            logic [7:0] got;
            int         base;
            base = 2 + i * FR;
            for (int j = 0; j < 8; j++) got[j] = rec_tx[base + (j + 1) * CD + CD/2];
            check({tag, " byte"}, got, exp[8*i +: 8]);
            check({tag, " framing"}, {rec_tx[base + CD/2], rec_tx[base + 9*CD + CD/2]}, 2'b01);
        end
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        reset = 1'b0; rx_in = 1'b1; play = 1'b0; clear = 1'b0;
        #12;
        check("rst tx_out", tx_out, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst count", count, 4'd0);
        check("rst flags", {full, overflow, framing_err}, 3'b000);
        @(posedge sysclk); #1;
        reset = 1'b1;
        tick(5);

        // play with an empty buffer is ignored
        play = 1'b1; tick(1); play = 1'b0; tick(3);
        check("play empty busy", busy, 1'b0);

        send_frame(8'h61, 1'b1, -1);
        send_frame(8'h62, 1'b1, -1);
        send_frame(8'h63, 1'b1, -1);
        check("abc count", count, 4'd3);
        play_check(3, 32'h00636261, "abc");

        pulse_clear();
        check("clear count", count, 4'd0);
        send_frame(8'h08, 1'b1, -1);
        check("bs at empty", count, 4'd0);
        send_frame(8'h61, 1'b1, -1);
        send_frame(8'h62, 1'b1, -1);
        send_frame(8'h08, 1'b1, -1);
        send_frame(8'h7A, 1'b1, -1);
        check("ab_bs_z count", count, 4'd2);
        play_check(2, 32'h00007A61, "abz");

        pulse_clear();
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        send_frame(8'h33, 1'b1, -1);
        send_frame(8'h44, 1'b1, -1);
        check("fill count", count, 4'd4);
        check("fill full/ovf", {full, overflow}, 2'b10);
        glitch(1'b1, "no echo when full");
        send_frame(8'h55, 1'b1, -1);
        check("ovf count", count, 4'd4);
        check("ovf flag", overflow, 1'b1);
        play_check(4, 32'h44332211, "full");

        pulse_clear();
        check("clear flags", {full, overflow}, 2'b00);
        glitch(1'b0, "echo low");
        check("glitch count", count, 4'd0);
        check("glitch ferr", framing_err, 1'b0);
        send_frame(8'h41, 1'b0, -1);
        tick(5);
        check("ferr flag", framing_err, 1'b1);
        check("ferr count", count, 4'd0);

        send_frame(8'h61, 1'b1, 40);
        check("play in rx busy", busy, 1'b0);
        check("play in rx count", count, 4'd1);

        play = 1'b1; tick(1); play = 1'b0;
        tick(50);
        check("mid play busy", busy, 1'b1);
        pulse_clear();
        check("clr play tx/busy", {tx_out, busy}, 2'b10);
        check("clr play count", count, 4'd0);

        // asynchronous reset in the middle of a received frame
        send_frame(8'h78, 1'b1, -1);
        rx_in = 1'b0;
        tick(30);
        #3 reset = 1'b0;
        #1;
        check("rst rx outs", {tx_out, busy, full, overflow, framing_err}, 5'b10000);
        check("rst rx count", count, 4'd0);
        rx_in = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(5);
        send_frame(8'h6B, 1'b1, -1);
        check("after rst count", count, 4'd1);
        play_check(1, 32'h0000006B, "after rst");

        // asynchronous reset in the middle of playback
        play = 1'b1; tick(1); play = 1'b0;
        tick(30);
        #3 reset = 1'b0;
        #1;
        check("rst tx outs", {tx_out, busy}, 2'b10);
        check("rst tx count", count, 4'd0);
        tick(2);
        reset = 1'b1;
        tick(5);
        send_frame(8'h6D, 1'b1, -1);
        check("after rst2 count", count, 4'd1);
        play_check(1, 32'h0000006D, "after rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
